// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO feeding the instruction register, with skip-squash,
// halt-word detection, flush and bubble indication.
module instr_prefetch_queue #(
    parameter int unsigned    INSN_W       = 16,
    parameter int unsigned    DEPTH        = 4,
    parameter int unsigned    SKIP_BIT     = 13,
    parameter logic [INSN_W-1:0] HALT_MASK    = 16'hD800,
    parameter logic [INSN_W-1:0] HALT_PATTERN = 16'hD800,
    parameter logic [INSN_W-1:0] NOP_WORD     = 16'h0000,
    parameter int unsigned    CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              fetch_valid_in,
    input  logic [INSN_W-1:0] fetch_data_in,
    output logic              fetch_ready_out,
    input  logic              ir_write_en_in,
    input  logic              cond_in,
    input  logic              flush_in,
    output logic [INSN_W-1:0] ir_data_out,
    output logic              ir_valid_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              halted_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [INSN_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INSN_W-1:0] ir_q, head;
    logic              ir_valid_q, halted_q;
    logic              push, pop, empty, squash, is_halt;

    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign squash  = head[SKIP_BIT] & ~cond_in;
    assign is_halt = ((head & HALT_MASK) == HALT_PATTERN);

    assign fetch_ready_out = ~reset_in & ~halted_q & ~flush_in & (count_q < CNT_W'(DEPTH));
    assign push = fetch_valid_in & fetch_ready_out;
    assign pop  = ir_write_en_in & ~halted_q & ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read when counted as valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fetch_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (flush_in) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
            if (ir_write_en_in) begin
                if (halted_q) begin
                    ir_q       <= NOP_WORD;
                    ir_valid_q <= 1'b1;
                end else if (empty) begin
                    ir_q       <= NOP_WORD;
                    ir_valid_q <= 1'b0;
                end else if (squash) begin
                    ir_q       <= NOP_WORD;
                    ir_valid_q <= 1'b1;
                end else begin
                    ir_q       <= head;
                    ir_valid_q <= 1'b1;
                    if (is_halt) halted_q <= 1'b1;
                end
            end
        end
    end

    assign ir_data_out  = ir_q;
    assign ir_valid_out = ir_valid_q;
    assign count_out    = count_q;
    assign halted_out   = halted_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: a queue-based reference model predicts
// IR/halt/count after every advance or reset; a monitor pops and compares.
module tb_instr_prefetch_queue;

    localparam int INSN_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [15:0] NOP = 16'h0000;

    logic              clk_in = 1'b0;
    logic              reset_in = 1'b1;
    logic              fetch_valid_in = 1'b0;
    logic [INSN_W-1:0] fetch_data_in = '0;
    logic              fetch_ready_out;
    logic              ir_write_en_in = 1'b0;
    logic              cond_in = 1'b0;
    logic              flush_in = 1'b0;
    logic [INSN_W-1:0] ir_data_out;
    logic              ir_valid_out;
    logic [CNT_W-1:0]  count_out;
    logic              halted_out;

    always #5 clk_in = ~clk_in;

    instr_prefetch_queue dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .fetch_valid_in  (fetch_valid_in),
        .fetch_data_in   (fetch_data_in),
        .fetch_ready_out (fetch_ready_out),
        .ir_write_en_in  (ir_write_en_in),
        .cond_in         (cond_in),
        .flush_in        (flush_in),
        .ir_data_out     (ir_data_out),
        .ir_valid_out    (ir_valid_out),
        .count_out       (count_out),
        .halted_out      (halted_out)
    );

    typedef struct {
        logic [15:0] ir;
        logic        v;
        logic        h;
        int          cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mq[$];
    bit          m_halt = 1'b0;
    logic [15:0] m_ir = NOP;
    bit          m_v = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [15:0] d,
                         input bit adv, input bit cond, input bit fl);
        bit          exp_rdy;
        logic [15:0] head;
        exp_t        e;
        @(negedge clk_in);
        reset_in       = rst;
        fetch_valid_in = v;
        fetch_data_in  = d;
        ir_write_en_in = adv;
        cond_in        = cond;
        flush_in       = fl;
        #1;
        exp_rdy = !rst && !m_halt && !fl && (mq.size() < DEPTH);
        chk("fetch_ready", {31'd0, fetch_ready_out}, {31'd0, exp_rdy});
        chk("count_now", 32'(count_out), 32'(mq.size()));
        if (rst) begin
            mq.delete();
            m_halt = 1'b0;
            m_ir   = NOP;
            m_v    = 1'b0;
        end else begin
            if (adv) begin
                if (m_halt) begin
                    m_ir = NOP;
                    m_v  = 1'b1;
                end else if (mq.size() == 0) begin
                    m_ir = NOP;
                    m_v  = 1'b0;
                end else begin
                    head = mq.pop_front();
                    m_v  = 1'b1;
                    if (head[13] && !cond) begin
                        m_ir = NOP;
                    end else begin
                        m_ir = head;
                        if ((head & 16'hD800) == 16'hD800) m_halt = 1'b1;
                    end
                end
            end
            if (fl) mq.delete();
            if (v && exp_rdy) mq.push_back(d);
        end
        if (rst || adv) begin
            e.ir  = m_ir;
            e.v   = m_v;
            e.h   = m_halt;
            e.cnt = mq.size();
            sb.push_back(e);
        end
    endtask

    task automatic push_w(input logic [15:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv_c(input bit cond);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, cond, 1'b0);
    endtask

    // Monitor: compares after every edge on which an advance or reset was applied.
    initial begin
        bit   seen;
        exp_t e;
        @(negedge clk_in);
        forever begin
            @(posedge clk_in);
            seen = reset_in | ir_write_en_in;
            #1;
            if (seen) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ir_data", 32'(ir_data_out), 32'(e.ir));
                    chk("ir_valid", {31'd0, ir_valid_out}, {31'd0, e.v});
                    chk("halted", {31'd0, halted_out}, {31'd0, e.h});
                    chk("count", 32'(count_out), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        push_w(16'h1111); push_w(16'h2222); push_w(16'h3333);
        repeat (4) adv_c(1'b0);

        push_w(16'h2005); adv_c(1'b0);
        push_w(16'h2005); adv_c(1'b1);

        for (int i = 1; i <= 4; i++) push_w(16'hA000 + 16'(i));
        cycle(1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        adv_c(1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 16'hB000 + 16'(i), 1'b1, 1'b1, 1'b0);
        repeat (4) adv_c(1'b1);

        push_w(16'hD800); push_w(16'h1234);
        adv_c(1'b1);
        cycle(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        push_w(16'hF800); adv_c(1'b0); adv_c(1'b0);

        push_w(16'h0101); push_w(16'h0202); push_w(16'h0303);
        cycle(1'b0, 1'b1, 16'h0404, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        push_w(16'hD800); push_w(16'h1111); push_w(16'h2222);
        adv_c(1'b1);
        cycle(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom);
            if (((d & 16'hD800) == 16'hD800) && ($urandom % 8 != 0)) d[15] = 1'b0;
            cycle(($urandom % 48) == 0, ($urandom % 4) != 0, d, $urandom % 2 == 1,
                  $urandom % 2 == 1, ($urandom % 16) == 0);
        end

        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised successor to the CPU's single instruction register. It adds a DEPTH-entry prefetch FIFO between the fetch path and the instruction register (IR), so memory fetch can run ahead of execution. It keeps and generalises the existing behaviours: conditional-skip squash to NOP and halt-word detection. It adds queue flush, a bubble indication and a sticky halted flag.

## Interface
Parameters:
- INSN_W, 16, instruction width in bits
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2
- SKIP_BIT, 13, instruction bit marking "execute only if cond_in"
- HALT_MASK, 16'hD800, bits compared for halt detection
- HALT_PATTERN, 16'hD800, halt when (word & HALT_MASK) == HALT_PATTERN
- NOP_WORD, 16'h0000, word substituted for squashed, bubble and post-halt slots
- CNT_W, $clog2(DEPTH+1), derived; not to be overridden

Ports:
- clk_in  in  1  clock; all state updates on posedge
- reset_in  in  1  synchronous, active-high reset
- fetch_valid_in  in  1  fetch_data_in holds a valid instruction word
- fetch_data_in  in  INSN_W  fetched instruction word
- fetch_ready_out  out  1  queue accepts a word this cycle
- ir_write_en_in  in  1  advance: load the next instruction into the IR
- cond_in  in  1  skip condition, sampled on an advance
- flush_in  in  1  discard all queued words (branch taken)
- ir_data_out  out  INSN_W  current IR contents (registered)
- ir_valid_out  out  1  IR holds a real or squashed slot, not a bubble
- count_out  out  CNT_W  number of queued words
- halted_out  out  1  sticky; a halt word has been loaded

## Operation
- Push: occurs when fetch_valid_in & fetch_ready_out. The word is written at the tail and count increments.
- fetch_ready_out = ~reset_in & ~halted_out & ~flush_in & (count_out < DEPTH). It is combinational from state and these inputs only, with no path from fetch_valid_in.
- Advance (ir_write_en_in=1) is evaluated in priority order:
  1. halted_out=1: IR<=NOP_WORD, ir_valid_out<=1, no pop.
  2. Queue empty: IR<=NOP_WORD, ir_valid_out<=0 (bubble).
  3. Otherwise pop the head, then:
     - head[SKIP_BIT] & ~cond_in: squash, IR<=NOP_WORD, ir_valid_out<=1.
     - Else: IR<=head, ir_valid_out<=1.
     - If the unsquashed head matches the halt pattern: halted_out<=1 on the same edge as the load.
- A squashed halt word does not halt.
- No advance: IR, ir_valid_out and halted_out hold.
- Flush: read/write pointers and count are set to 0. IR, ir_valid_out and halted_out are unaffected.
- Simultaneous events:
  - Push + pop: count unchanged, both take effect.
  - Advance + flush: the advance consumes the current head (normal pop rules), then the remaining entries are discarded, so count_out=0 next cycle.
  - Push into an empty queue + advance: no bypass. The advance sees empty and produces a bubble, and the word is enqueued.
- Pointers are log2(DEPTH) bits and wrap naturally. count_out ranges 0..DEPTH inclusive.
- halted_out clears only on reset_in.

## Timing
- Reset (takes effect on the edge with reset_in=1): ir_data_out=NOP_WORD, ir_valid_out=0, count_out=0, halted_out=0, pointers=0. fetch_ready_out=0 while reset_in=1, and 1 on the first cycle after.
- Reset mid-operation discards all queued words and clears halt regardless of other inputs. Reset has top priority.
- Latency:
  - A word pushed at edge N can be loaded into the IR at edge N+1 at the earliest.
  - ir_data_out changes on the advance edge itself.
- A full queue drops fetch_ready_out in the same cycle that count_out reaches DEPTH. Ready rises the cycle after a pop.
- All outputs except fetch_ready_out are registered.

## Test plan
- Reset, push 0x1111, 0x2222, 0x3333 on consecutive cycles, then advance ×4 -> IR sequence 0x1111, 0x2222, 0x3333, NOP with ir_valid 1,1,1,0; count_out 3,2,1,0,0.
- Push 0x2005 (bit13 set), advance with cond_in=0 -> IR=0x0000, ir_valid_out=1, count decremented. Repeat with cond_in=1 -> IR=0x2005.
- Fill 4 words -> fetch_ready_out=0 while count_out=4. Push+advance in the same cycle when count is 3 -> count stays 3 and FIFO order is preserved across pointer wrap over 20 words.
- Queue 0xD800, 0x1234 and advance -> IR=0xD800, halted_out=1. Next advance -> IR=0x0000, count stays 1, fetch_ready_out=0. Squashed 0xF800 with cond_in=0 -> no halt.
- Queue 3 words, assert advance+flush together -> IR=first word, count_out=0. A push attempted that cycle is refused (ready=0).
- Assert reset_in with 2 queued words and halted_out=1 -> all outputs at reset values next cycle, fetch_ready_out=1 after reset deasserts.
